// File: rtl/calc2_sched_pkg.sv
// Shared types and fixed configuration for the calc2 port scheduler.
// Four ports, four tags per port, a 16-entry result FIFO and an 8-bit id.
package calc2_sched_pkg;
    localparam int NUM_PORTS     = 4;
    localparam int PORT_W        = 2;
    localparam int TAGS_PER_PORT = 4;
    localparam int TAG_W         = 2;
    localparam int RESULT_DEPTH  = 16;
    localparam int ID_W          = 8;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_t;

    typedef enum logic [1:0] {
        RESP_NONE    = 2'd0,
        RESP_OK      = 2'd1,
        RESP_OVF     = 2'd2,
        RESP_INVALID = 2'd3
    } resp_t;

    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_CMD   = 2'd1;
    localparam sched_state_t ST_DATA2 = 2'd2;

    typedef struct packed {
        resp_t            resp;
        logic [31:0]      data;
        logic [ID_W-1:0]  id;
    } result_t;
endpackage

// File: rtl/calc2_port_scheduler_if.sv
// Upstream operation stream and result stream of the calc2 port scheduler.
interface calc2_port_scheduler_if;
    import calc2_sched_pkg::*;

    logic            op_valid;
    logic            op_ready;
    logic [3:0]      op_cmd;
    logic [31:0]     op_data1;
    logic [31:0]     op_data2;
    logic [ID_W-1:0] op_id;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_resp;
    logic [31:0]     res_data;
    logic [ID_W-1:0] res_id;

    modport master (
        output op_valid, op_cmd, op_data1, op_data2, op_id, res_ready,
        input  op_ready, res_valid, res_resp, res_data, res_id
    );

    modport slave (
        input  op_valid, op_cmd, op_data1, op_data2, op_id, res_ready,
        output op_ready, res_valid, res_resp, res_data, res_id
    );
endinterface

// File: rtl/calc2_result_fifo.sv
// Result FIFO with several write ports per cycle (packed in port order) and one
// first-word-fall-through read port.
module calc2_result_fifo
    import calc2_sched_pkg::*;
#(
    parameter int WR_PORTS = NUM_PORTS + 1,
    parameter int DEPTH    = RESULT_DEPTH,
    parameter int PTR_W    = 4,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WR_PORTS-1:0] wr_en,
    input  result_t          wr_data [WR_PORTS],
    input  logic             rd_en,
    output result_t          rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count
);
    result_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] slot_s [WR_PORTS];
    logic [CNT_W-1:0] n_wr_s;
    logic             pop_s;

    // Each enabled writer lands after all enabled writers with a lower index
    always_comb begin
        n_wr_s = '0;
        for (int i = 0; i < WR_PORTS; i++) begin
            slot_s[i] = wr_ptr_r + n_wr_s[PTR_W-1:0];
            if (wr_en[i]) begin
                n_wr_s = n_wr_s + CNT_W'(1);
            end else begin
                n_wr_s = n_wr_s;
            end
        end
    end

    assign pop_s    = rd_en && (count_r != '0);
    assign rd_valid = (count_r != '0);
    assign rd_data  = mem_r[rd_ptr_r];
    assign count    = count_r;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + n_wr_s[PTR_W-1:0];
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            count_r  <= count_r + n_wr_s - CNT_W'(pop_s);
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_PORTS; i++) begin
            if (wr_en[i]) begin
                mem_r[slot_s[i]] <= wr_data[i];
            end
        end
    end
endmodule

// File: rtl/calc2_port_scheduler.sv
// Dispatches upstream operations round-robin over the four calc2 request ports,
// tracks tags per port and returns matched responses through a result FIFO.
module calc2_port_scheduler
    import calc2_sched_pkg::*;
(
    input  logic                              c_clk,
    input  logic                              reset,
    calc2_port_scheduler_if.slave             up,
    output logic [NUM_PORTS-1:0][3:0]         req_cmd_out,
    output logic [NUM_PORTS-1:0][31:0]        req_data_out,
    output logic [NUM_PORTS-1:0][TAG_W-1:0]   req_tag_out,
    input  logic [NUM_PORTS-1:0][1:0]         resp_in,
    input  logic [NUM_PORTS-1:0][31:0]        data_in,
    input  logic [NUM_PORTS-1:0][TAG_W-1:0]   tag_in,
    output logic [4:0]                        outstanding,
    output logic                              err_spurious
);
    sched_state_t                          state_r;
    logic [PORT_W-1:0]                     rr_ptr_r;
    logic [NUM_PORTS-1:0][TAGS_PER_PORT-1:0] busy_r;
    logic [ID_W-1:0]                       id_tab_r [NUM_PORTS][TAGS_PER_PORT];
    logic [PORT_W-1:0]                     cur_port_r;
    logic [31:0]                           cur_data2_r;
    logic                                  nop_push_r;
    logic [ID_W-1:0]                       nop_id_r;
    logic [4:0]                            outstanding_r;
    logic                                  err_r;
    logic [NUM_PORTS-1:0][3:0]             req_cmd_r;
    logic [NUM_PORTS-1:0][31:0]            req_data_r;
    logic [NUM_PORTS-1:0][TAG_W-1:0]       req_tag_r;

    logic              sel_found_s;
    logic [PORT_W-1:0] sel_port_s;
    logic [TAG_W-1:0]  sel_tag_s;
    logic [4:0]        fifo_count_s;
    logic              credit_ok_s;
    logic              op_ready_s;
    logic              accept_s;
    logic              dispatch_s;
    logic [NUM_PORTS-1:0] rsp_hit_s;
    logic [NUM_PORTS-1:0] rsp_spur_s;
    logic [NUM_PORTS:0]   fifo_wr_en_s;
    result_t           fifo_wr_data_s [NUM_PORTS+1];
    result_t           fifo_rd_s;
    logic [2:0]        n_push_s;

    // First port from rr_ptr with a free tag, then that port's lowest free tag
    always_comb begin
        sel_found_s = 1'b0;
        sel_port_s  = '0;
        sel_tag_s   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!sel_found_s && !(&busy_r[rr_ptr_r + PORT_W'(k)])) begin
                sel_found_s = 1'b1;
                sel_port_s  = rr_ptr_r + PORT_W'(k);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        for (int t = TAGS_PER_PORT - 1; t >= 0; t--) begin
            if (!busy_r[sel_port_s][t]) begin
                sel_tag_s = TAG_W'(t);
            end else begin
                sel_tag_s = sel_tag_s;
            end
        end
    end

    // Credit covers both queued results and everything still in flight
    assign credit_ok_s = (6'(fifo_count_s) + 6'(outstanding_r)) < 6'(RESULT_DEPTH);
    assign op_ready_s  = ((state_r == ST_IDLE) || (state_r == ST_DATA2)) && sel_found_s && credit_ok_s;
    assign accept_s    = up.op_valid && op_ready_s;
    assign dispatch_s  = accept_s && (up.op_cmd != 4'd0);

    // Response matching and FIFO write-port assembly (no-op results go last)
    always_comb begin
        n_push_s = 3'd0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_hit_s[p]      = (resp_in[p] != 2'd0) && busy_r[p][tag_in[p]];
            rsp_spur_s[p]     = (resp_in[p] != 2'd0) && !busy_r[p][tag_in[p]];
            fifo_wr_data_s[p] = '{resp: resp_t'(resp_in[p]), data: data_in[p], id: id_tab_r[p][tag_in[p]]};
        end
        fifo_wr_data_s[NUM_PORTS] = '{resp: RESP_INVALID, data: 32'd0, id: nop_id_r};
        fifo_wr_en_s = {nop_push_r, rsp_hit_s};
        for (int i = 0; i <= NUM_PORTS; i++) begin
            n_push_s = n_push_s + 3'(fifo_wr_en_s[i]);
        end
    end

    // Dispatch FSM, request drive registers and tag bookkeeping
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= '0;
            busy_r        <= '0;
            cur_port_r    <= '0;
            cur_data2_r   <= '0;
            nop_push_r    <= 1'b0;
            nop_id_r      <= '0;
            outstanding_r <= '0;
            err_r         <= 1'b0;
            req_cmd_r     <= '0;
            req_data_r    <= '0;
            req_tag_r     <= '0;
        end else begin
            nop_push_r    <= accept_s && !dispatch_s;
            nop_id_r      <= up.op_id;
            outstanding_r <= outstanding_r + 5'(accept_s) - 5'(n_push_s);
            err_r         <= err_r | (|rsp_spur_s);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rsp_hit_s[p]) begin
                    busy_r[p][tag_in[p]] <= 1'b0;
                end
            end
            req_cmd_r  <= '0;
            req_data_r <= '0;
            req_tag_r  <= '0;
            if (dispatch_s) begin
                busy_r[sel_port_s][sel_tag_s] <= 1'b1;
                rr_ptr_r                      <= sel_port_s + PORT_W'(1);
                cur_port_r                    <= sel_port_s;
                cur_data2_r                   <= up.op_data2;
                req_cmd_r[sel_port_s]         <= up.op_cmd;
                req_data_r[sel_port_s]        <= up.op_data1;
                req_tag_r[sel_port_s]         <= sel_tag_s;
                state_r                       <= ST_CMD;
            end else if (state_r == ST_CMD) begin
                req_data_r[cur_port_r] <= cur_data2_r;
                req_tag_r[cur_port_r]  <= req_tag_r[cur_port_r];
                state_r                <= ST_DATA2;
            end else begin
                state_r <= ST_IDLE;
            end
        end
    end

    // Id table travels with the tag; only meaningful while the tag is busy
    always_ff @(posedge c_clk) begin
        if (dispatch_s) begin
            id_tab_r[sel_port_s][sel_tag_s] <= up.op_id;
        end
    end

    calc2_result_fifo u_fifo (
        .clk      (c_clk),
        .reset    (reset),
        .wr_en    (fifo_wr_en_s),
        .wr_data  (fifo_wr_data_s),
        .rd_en    (up.res_ready),
        .rd_data  (fifo_rd_s),
        .rd_valid (up.res_valid),
        .count    (fifo_count_s)
    );

    assign up.op_ready   = op_ready_s;
    assign up.res_resp   = fifo_rd_s.resp;
    assign up.res_data   = fifo_rd_s.data;
    assign up.res_id     = fifo_rd_s.id;
    assign req_cmd_out   = req_cmd_r;
    assign req_data_out  = req_data_r;
    assign req_tag_out   = req_tag_r;
    assign outstanding   = outstanding_r;
    assign err_spurious  = err_r;
endmodule

// File: tb/tb_calc2_port_scheduler.sv
// Scoreboard bench: expected results are queued when responses or no-op
// operations are driven and compared when the scheduler pops them.
module tb_calc2_port_scheduler;
    logic               c_clk = 1'b0;
    logic               reset;
    logic [3:0][3:0]    req_cmd_out;
    logic [3:0][31:0]   req_data_out;
    logic [3:0][1:0]    req_tag_out;
    logic [3:0][1:0]    resp_in;
    logic [3:0][31:0]   data_in;
    logic [3:0][1:0]    tag_in;
    logic [4:0]         outstanding;
    logic               err_spurious;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [7:0]  id;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_id [4][4];
    int         n_checks = 0;
    int         n_fail = 0;

    calc2_port_scheduler_if bus ();

    calc2_port_scheduler dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .up           (bus.slave),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .req_tag_out  (req_tag_out),
        .resp_in      (resp_in),
        .data_in      (data_in),
        .tag_in       (tag_in),
        .outstanding  (outstanding),
        .err_spurious (err_spurious)
    );

    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result collector: compare every popped result against the scoreboard
    always @(negedge c_clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {56'd0, bus.res_id}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_resp", 64'(bus.res_resp), 64'(e.resp));
                check("res_data", 64'(bus.res_data), 64'(e.data));
                check("res_id",   64'(bus.res_id),   64'(e.id));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge c_clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [7:0] id);
        int n = 0;
        bus.op_valid = 1'b1;
        bus.op_cmd   = cmd;
        bus.op_data1 = d1;
        bus.op_data2 = d2;
        bus.op_id    = id;
        while (!bus.op_ready && n < 50) begin
            @(posedge c_clk); #1;
            n++;
        end
        if (!bus.op_ready) begin
            check("op_ready_timeout", 64'(bus.op_ready), 64'd1);
        end else begin
            @(posedge c_clk); #1;
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic respond(input int p, input logic [1:0] rsp, input logic [31:0] d,
                           input logic [1:0] t, input bit hit);
        exp_t e;
        resp_in[p] = rsp;
        data_in[p] = d;
        tag_in[p]  = t;
        if (hit) begin
            e.resp = rsp;
            e.data = d;
            e.id   = exp_id[p][t];
            exp_q.push_back(e);
        end
    endtask

    task automatic resp_cycle();
        @(posedge c_clk); #1;
        resp_in = '0;
        data_in = '0;
        tag_in  = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge c_clk); #1;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic issue(input int p, input int t, input logic [3:0] cmd, input logic [7:0] id);
        exp_id[p][t] = id;
        send_op(cmd, 32'(id) * 32'd3, 32'(id) + 32'd9, id);
        check("rr_cmd", 64'(req_cmd_out), 64'(16'(32'(cmd) << (4 * p))));
        check("rr_tag", 64'(req_tag_out[p]), 64'(t));
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_cmd    = 4'd0;
        bus.op_data1  = 32'd0;
        bus.op_data2  = 32'd0;
        bus.op_id     = 8'd0;
        bus.res_ready = 1'b1;
        resp_in = '0;
        data_in = '0;
        tag_in  = '0;

        // Reset state
        do_reset();
        check("rst_req_cmd", 64'(req_cmd_out), 64'd0);
        check("rst_op_ready", 64'(bus.op_ready), 64'd1);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err_spurious), 64'd0);

        // Single add on port 0
        exp_id[0][0] = 8'h11;
        send_op(4'd1, 32'd5, 32'd7, 8'h11);
        check("add_cmd", 64'(req_cmd_out), 64'h1);
        check("add_data1", 64'(req_data_out[0]), 64'd5);
        check("add_tag", 64'(req_tag_out[0]), 64'd0);
        @(posedge c_clk); #1;
        check("add_cmd2", 64'(req_cmd_out), 64'd0);
        check("add_data2", 64'(req_data_out[0]), 64'd7);
        check("add_outstanding", 64'(outstanding), 64'd1);
        respond(0, 2'd1, 32'd5 + 32'd7, 2'd0, 1'b1);
        resp_cycle();
        check("add_outstanding_done", 64'(outstanding), 64'd0);
        drain("add_drain");

        // Round robin and tag allocation
        do_reset();
        for (int i = 0; i < 5; i++) issue(i % 4, i / 4, 4'd2, 8'(8'h30 + i));
        check("rr_outstanding", 64'(outstanding), 64'd5);
        for (int i = 0; i < 5; i++) begin
            respond(i % 4, 2'd1, 32'(32'h100 + i), 2'(i / 4), 1'b1);
            resp_cycle();
        end
        drain("rr_drain");

        // Tag exhaustion, then credit limit from a full FIFO
        do_reset();
        for (int i = 0; i < 16; i++) issue(i % 4, i / 4, 4'd1, 8'(8'h40 + i));
        repeat (2) @(posedge c_clk);
        #1;
        check("exh_op_ready", 64'(bus.op_ready), 64'd0);
        check("exh_outstanding", 64'(outstanding), 64'd16);
        bus.res_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            for (int p = 0; p < 4; p++) respond(p, 2'(1 + (p % 2)), 32'(32'h200 + 4 * t + p), 2'(t), 1'b1);
            resp_cycle();
        end
        check("credit_op_ready", 64'(bus.op_ready), 64'd0);
        check("credit_res_valid", 64'(bus.res_valid), 64'd1);
        check("credit_outstanding", 64'(outstanding), 64'd0);
        bus.res_ready = 1'b1;
        @(posedge c_clk); #1;
        bus.res_ready = 1'b0;
        check("credit_after_pop", 64'(bus.op_ready), 64'd1);
        bus.res_ready = 1'b1;
        drain("credit_drain");

        // Four simultaneous responses
        do_reset();
        for (int i = 0; i < 4; i++) issue(i, 0, 4'd5, 8'(i + 1));
        repeat (2) @(posedge c_clk);
        #1;
        check("sim_outstanding4", 64'(outstanding), 64'd4);
        for (int p = 0; p < 4; p++) respond(p, 2'd1, 32'(32'h300 + p), 2'd0, 1'b1);
        resp_cycle();
        check("sim_outstanding0", 64'(outstanding), 64'd0);
        drain("sim_drain");

        // No-op command bypasses the ports
        begin
            exp_t e;
            e.resp = 2'd3;
            e.data = 32'd0;
            e.id   = 8'h22;
            exp_q.push_back(e);
        end
        send_op(4'd0, 32'hDEAD, 32'hBEEF, 8'h22);
        check("nop_req_cmd", 64'(req_cmd_out), 64'd0);
        check("nop_req_data", 64'(req_data_out[0] | req_data_out[1] | req_data_out[2] | req_data_out[3]), 64'd0);
        check("nop_outstanding", 64'(outstanding), 64'd1);
        @(posedge c_clk); #1;
        check("nop_outstanding_done", 64'(outstanding), 64'd0);
        drain("nop_drain");

        // Response on a tag that was never issued
        check("spur_err_before", 64'(err_spurious), 64'd0);
        respond(2, 2'd1, 32'd99, 2'd3, 1'b0);
        resp_cycle();
        check("spur_err", 64'(err_spurious), 64'd1);
        check("spur_no_result", 64'(bus.res_valid), 64'd0);
        check("spur_outstanding", 64'(outstanding), 64'd0);
        repeat (3) @(posedge c_clk);
        #1;
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/calc2_port_scheduler.md
Name: calc2_port_scheduler

Overview:
- Front-end dispatcher that shares the four calc2 request ports among one upstream operation stream.
- Accepts whole operations (cmd, operand1, operand2, id) on a valid/ready interface and picks a port round-robin with a lowest-free tag.
- Drives the two-cycle calc2 request protocol, tracks outstanding tags per port, matches responses by (port, tag), and returns results with the original id through a result FIFO.
- Sits between the test stimulus and calc2_top, replacing per-port drivers.

Parameters:
- NUM_PORTS, 4: calc2 request ports served; index p=0..3 maps to calc2 port p+1.
- TAGS_PER_PORT, 4: tags per port; tag width 2.
- RESULT_DEPTH, 16: result FIFO entries.
- ID_W, 8: upstream id width.

Ports:
- c_clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op_valid  in  1  upstream operation valid
- op_ready  out  1  upstream ready
- op_cmd  in  4  calc2 command
- op_data1  in  32  operand 1
- op_data2  in  32  operand 2
- op_id  in  ID_W  id returned with result
- req_cmd_out  out  NUM_PORTS x4  to calc2 reqN_cmd_in
- req_data_out  out  NUM_PORTS x32  to calc2 reqN_data_in
- req_tag_out  out  NUM_PORTS x2  to calc2 reqN_tag_in
- resp_in  in  NUM_PORTS x2  from calc2 out_respN
- data_in  in  NUM_PORTS x32  from calc2 out_dataN
- tag_in  in  NUM_PORTS x2  from calc2 out_tagN
- res_valid  out  1  result valid
- res_ready  in  1  result ready
- res_resp  out  2  response code
- res_data  out  32  result data
- res_id  out  ID_W  id of completed operation
- outstanding  out  5  operations accepted but not yet in the FIFO
- err_spurious  out  1  sticky: response on an idle tag

Behaviour:
- Reset (c_clk edge with reset=1): all req_* outputs 0, FSM IDLE, tag table cleared, FIFO empty, rr_ptr=0, res_valid=0, outstanding=0, err_spurious=0. Reset mid-operation discards in-flight operations; later calc2 responses for them set err_spurious.
- Dispatch FSM states IDLE, CMD, DATA2.
  - op_ready=1 only in IDLE or DATA2, when at least one port has a free tag and credit>0.
  - credit = RESULT_DEPTH - fifo_count - outstanding.
  - Accept (op_valid&op_ready): port = first port from rr_ptr (wrapping) with a free tag; tag = its lowest free index. Mark the tag busy, store id in table[port][tag], set rr_ptr=port+1 mod NUM_PORTS, go to CMD.
  - CMD (1 cycle): on the chosen port, cmd=op_cmd, data=op_data1, tag=tag. Other ports drive 0. Go to DATA2.
  - DATA2 (1 cycle): chosen port drives cmd=0, data=op_data2. An accept in this cycle goes to CMD, otherwise IDLE. Peak rate is one operation per 2 cycles.
- op_cmd==0: accepted but not dispatched, and no state change beyond IDLE. The FIFO is pushed next cycle with resp=3, data=0, id; consumes one credit.
- Response capture: each cycle, every port p with resp_in[p]!=0 and table[p][tag_in[p]] busy pushes {resp_in, data_in, id} to the FIFO and frees the tag. The freed tag is usable from the next cycle.
  - Up to NUM_PORTS pushes per cycle, in ascending port order.
  - Credit accounting guarantees no overflow.
  - A response to a non-busy tag is dropped and sets err_spurious.
- FIFO output: first-word-fall-through; pop on res_valid&res_ready. res_* are held stable while res_valid=1 and res_ready=0.
- outstanding: +1 per accept, -1 per FIFO push. Accept and push in the same cycle leaves it unchanged.

Decomposition:
- Package calc2_sched_pkg holds:
  - cmd_t (4-bit; CMD_NOP=0, ADD=1, SUB=2, SHL=5, SHR=6)
  - resp_t (NONE=0, OK=1, OVF=2, INVALID=3)
  - sched_state_t
  - result_t struct {resp, data, id}
  - tag width constant
- Sub-module calc2_result_fifo: multi-write (NUM_PORTS+1 ports), single-read, with count output.

Test Plan:
- Reset: hold reset 2 cycles -> req_cmd_out all 0, op_ready=1, res_valid=0, outstanding=0, err_spurious=0.
- Single add: cmd=1, d1=5, d2=7, id=0x11 accepted at t -> port0 drives cmd1/data5/tag0 at t+1 and cmd0/data7 at t+2. Model returns resp1, data12, tag0 -> res_valid with id=0x11, data=12, resp=1.
- Round-robin and tags: 5 back-to-back ops, no responses -> ports 0,1,2,3 get tag0, fifth goes to port0 tag1. outstanding=5.
- Exhaustion and credit:
  - 16 ops with responses withheld -> op_ready=0 after the 16th.
  - Then all respond with res_ready=0 -> FIFO count=16, op_ready stays 0 despite free tags.
  - One pop -> op_ready=1.
- Simultaneous responses: all 4 ports respond in the same cycle with ids 1..4 -> results popped in order 1,2,3,4; outstanding drops 4 to 0 in one cycle.
- Boundaries:
  - op_cmd=0, id=0x22 -> no port activity; result resp=3, data=0, id=0x22.
  - resp=1 on port2 tag3 never issued -> err_spurious=1, no result pushed.
